// File: rtl/l1_l2_request_arbiter_pkg.sv
// Shared L1->L2 request types: packet layout, requester unit encodings and arbiter FSM states.
// Every block on the L1/L2 request path imports this package.
package l1_l2_request_arbiter_pkg;

  localparam int CORE_W = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam int REQ_ICACHE = 0;
  localparam int REQ_DCACHE = 1;
  localparam int REQ_STB    = 2;

  typedef enum logic [1:0] {
    UNIT_ICACHE = 2'd0,
    UNIT_DCACHE = 2'd1,
    UNIT_STB    = 2'd2,
    UNIT_RSVD   = 2'd3
  } unit_id_t;

  typedef struct packed {
    logic              valid;
    logic [CORE_W-1:0] core;
    unit_id_t          unit_id;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } l2req_packet_t;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } arb_state_t;

  // Marks a packet as owned by this core and live on the L2 request bus.
  function automatic l2req_packet_t stamp_packet(l2req_packet_t p, logic [CORE_W-1:0] core);
    l2req_packet_t r;
    r       = p;
    r.valid = 1'b1;
    r.core  = core;
    return r;
  endfunction

endpackage

// File: rtl/l1_l2_request_arbiter_if.sv
// Requester-side and L2-side signals of the L1->L2 request arbiter.
// master is the arbiter's view; slave is the view of the surrounding requesters and L2.
interface l1_l2_request_arbiter_if
  import l1_l2_request_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3
);

  logic          [NUM_REQ-1:0] req_i;
  l2req_packet_t [NUM_REQ-1:0] req_packet_i;
  logic          [NUM_REQ-1:0] grant_o;
  logic                        l2req_ready;
  l2req_packet_t               l2req_packet;
  logic                        pc_event_l2_stall;

  modport master (
    input  req_i,
    input  req_packet_i,
    input  l2req_ready,
    output grant_o,
    output l2req_packet,
    output pc_event_l2_stall
  );

  modport slave (
    output req_i,
    output req_packet_i,
    output l2req_ready,
    input  grant_o,
    input  l2req_packet,
    input  pc_event_l2_stall
  );

endinterface

// File: rtl/l1_l2_request_arbiter_rr.sv
// Generic round-robin picker: first set request at or above pointer, wrapping modulo N.
// Purely combinational; the caller owns the pointer and decides when a grant is taken.
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  request,
  input  logic [PW-1:0] pointer,
  output logic [N-1:0]  grant
);

  int            pos;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    pos   = 0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(pointer) + k) % N;
      idx = PW'(pos);
      if (!found && request[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/l1_l2_request_arbiter.sv
// Round-robin arbiter from the L1 miss queues / store buffer into one registered L2 request slot.
// Latency 1 cycle grant->valid; slot holds bit-stable and withholds grants while l2req_ready is low.
module l1_l2_request_arbiter
  import l1_l2_request_arbiter_pkg::*;
#(
  parameter int CORE_ID = 0,
  parameter int NUM_REQ = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  l1_l2_request_arbiter_if.master bus
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t          state;
  arb_state_t          state_nxt;
  logic [PW-1:0]       rr_ptr;
  logic [PW-1:0]       rr_ptr_nxt;
  l2req_packet_t       pkt_q;
  l2req_packet_t       pkt_nxt;
  logic [NUM_REQ-1:0]  arb_grant;
  logic [NUM_REQ-1:0]  grant;
  logic                load_ok;
  l2req_packet_t       sel_pkt;
  logic [PW-1:0]       grant_idx;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .request (bus.req_i),
    .pointer (rr_ptr),
    .grant   (arb_grant)
  );

  // The slot can take a new packet when empty, or when its current one leaves this cycle.
  assign load_ok = (state == IDLE) || ((state == PRESENT) && bus.l2req_ready);
  assign grant   = (load_ok && reset_n) ? arb_grant : '0;

  always_comb begin
    sel_pkt   = '0;
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_pkt   = bus.req_packet_i[i];
        grant_idx = PW'(i);
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    pkt_nxt    = pkt_q;
    rr_ptr_nxt = rr_ptr;
    if (load_ok) begin
      if (|grant) begin
        state_nxt  = PRESENT;
        pkt_nxt    = stamp_packet(sel_pkt, CORE_W'(CORE_ID));
        rr_ptr_nxt = (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + PW'(1);
      end else begin
        state_nxt  = IDLE;
        pkt_nxt    = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_q  <= '0;
      rr_ptr <= '0;
    end else begin
      pkt_q  <= pkt_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  assign bus.grant_o           = grant;
  assign bus.l2req_packet      = pkt_q;
  assign bus.pc_event_l2_stall = (state == PRESENT) && !bus.l2req_ready;

  a_grant_onehot0 : assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(bus.grant_o));

  a_grant_has_req : assert property (@(posedge clk) disable iff (!reset_n)
    ((bus.grant_o & ~bus.req_i) == '0));

endmodule

// File: tb/tb_l1_l2_request_arbiter.sv
// Randomized and directed bench for l1_l2_request_arbiter against a queue-free behavioural model.
module tb_l1_l2_request_arbiter;
  import l1_l2_request_arbiter_pkg::*;

  localparam int N      = 3;
  localparam int CORE_V = 1;

  logic clk;
  logic reset_n;

  l1_l2_request_arbiter_if #(.NUM_REQ(N)) bus ();

  l1_l2_request_arbiter #(.CORE_ID(CORE_V), .NUM_REQ(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // model of the output slot and round-robin pointer
  int            m_ptr;
  bit            m_valid;
  l2req_packet_t m_out;
  logic [N-1:0]  m_grant;
  int            m_g;

  logic [N-1:0]  obs_grant;
  logic          obs_valid;
  logic          obs_stall;
  l2req_packet_t obs_pkt;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic l2req_packet_t rand_pkt();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return l2req_packet_t'(t[$bits(l2req_packet_t)-1:0]);
  endfunction

  task automatic model_reset();
    m_ptr   = 0;
    m_valid = 1'b0;
    m_out   = '0;
    m_grant = '0;
  endtask

  // One clock: inputs are already driven; check at negedge, advance the model at posedge.
  task automatic cycle();
    bit            rdy;
    bit            take;
    l2req_packet_t cap;
    @(negedge clk);
    rdy     = bus.l2req_ready;
    take    = !m_valid || rdy;
    m_g     = take ? pick(bus.req_i, m_ptr) : -1;
    m_grant = (m_g >= 0) ? N'(1 << m_g) : '0;
    cap     = (m_g >= 0) ? bus.req_packet_i[m_g] : '0;
    obs_grant = bus.grant_o;
    obs_valid = bus.l2req_packet.valid;
    obs_stall = bus.pc_event_l2_stall;
    obs_pkt   = bus.l2req_packet;
    chk("grant",  128'(bus.grant_o), 128'(m_grant));
    chk("packet", 128'(bus.l2req_packet), 128'(m_out));
    chk("stall",  128'(bus.pc_event_l2_stall), 128'(m_valid && !rdy));
    chk("rr_ptr", 128'(dut.rr_ptr), 128'(m_ptr));
    chk("state",  128'(dut.state == PRESENT), 128'(m_valid));
    @(posedge clk);
    if (take) begin
      if (m_g >= 0) begin
        m_out       = cap;
        m_out.valid = 1'b1;
        m_out.core  = CORE_W'(CORE_V);
        m_valid     = 1'b1;
        m_ptr       = (m_g + 1) % N;
      end else begin
        m_out   = '0;
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    l2req_packet_t held;
    l2req_packet_t p;

    reset_n          = 1'b0;
    bus.req_i        = '0;
    bus.l2req_ready  = 1'b0;
    bus.req_packet_i = '0;
    model_reset();

    // requests asserted during reset must see no grant and an empty slot
    #12;
    bus.req_i = 3'b111;
    #1;
    chk("rst_grant", 128'(bus.grant_o), 128'(0));
    chk("rst_valid", 128'(bus.l2req_packet.valid), 128'(0));
    chk("rst_ptr",   128'(dut.rr_ptr), 128'(0));
    #9;
    reset_n = 1'b1;
    bus.req_i = '0;
    @(posedge clk); #1;

    // all requesters asserted, L2 always ready: strict 0,1,2,0,1,2 with no bubble
    for (int i = 0; i < N; i++) bus.req_packet_i[i] = rand_pkt();
    bus.req_i       = 3'b111;
    bus.l2req_ready = 1'b1;
    for (int s = 0; s < 6; s++) begin
      cycle();
      chk("rr_seq",    128'(obs_grant), 128'(1 << (s % N)));
      chk("seq_valid", 128'(obs_valid), 128'(s >= 1));
      for (int i = 0; i < N; i++) if (m_grant[i]) bus.req_packet_i[i] = rand_pkt();
    end

    // drain: last packet accepted, slot empties next cycle
    bus.req_i = '0;
    cycle();
    cycle();
    chk("drain_valid", 128'(obs_valid), 128'(0));

    // stall: one grant, packet held bit-identical for 4 cycles, no second grant
    p = rand_pkt();
    bus.req_packet_i[1] = p;
    bus.req_i           = 3'b010;
    bus.l2req_ready     = 1'b0;
    cycle();
    chk("stall_grant", 128'(obs_grant), 128'(3'b010));
    held       = p;
    held.valid = 1'b1;
    held.core  = CORE_W'(CORE_V);
    bus.req_packet_i[1] = rand_pkt();
    for (int s = 0; s < 4; s++) begin
      cycle();
      chk("stall_hold",  128'(obs_pkt), 128'(held));
      chk("stall_event", 128'(obs_stall), 128'(1));
      chk("stall_nogrt", 128'(obs_grant), 128'(0));
    end

    // accept-and-reload grants requester 1 again, pointer moves to 2
    bus.l2req_ready = 1'b1;
    cycle();
    chk("reload_grant", 128'(obs_grant), 128'(3'b010));

    // pointer at 2 with requests 0 and 1 wraps to requester 0
    chk("ptr_pre", 128'(dut.rr_ptr), 128'(2));
    bus.req_i = 3'b011;
    cycle();
    chk("wrap_grant", 128'(obs_grant), 128'(3'b001));
    chk("wrap_ptr",   128'(dut.rr_ptr), 128'(1));

    // single packet accepted with nothing behind it
    bus.req_i = '0;
    cycle();
    cycle();
    chk("idle_valid", 128'(obs_valid), 128'(0));
    chk("idle_state", 128'(dut.state == PRESENT), 128'(0));

    // core field is overwritten with this core's id
    p      = rand_pkt();
    p.core = 2'd3;
    bus.req_packet_i[0] = p;
    bus.req_i           = 3'b001;
    cycle();
    bus.req_i = '0;
    cycle();
    chk("core_stamp", 128'(obs_pkt.core), 128'(CORE_V));

    // async reset between edges while a packet is stalled
    cycle();
    bus.req_packet_i[0] = rand_pkt();
    bus.req_i           = 3'b001;
    bus.l2req_ready     = 1'b0;
    cycle();
    cycle();
    #3;
    reset_n   = 1'b0;
    bus.req_i = 3'b001;
    #1;
    chk("arst_valid", 128'(bus.l2req_packet.valid), 128'(0));
    chk("arst_ptr",   128'(dut.rr_ptr), 128'(0));
    chk("arst_grant", 128'(bus.grant_o), 128'(0));
    bus.req_i = '0;
    model_reset();
    #2;
    reset_n = 1'b1;
    @(posedge clk); #1;
    bus.req_packet_i[1] = rand_pkt();
    bus.req_packet_i[2] = rand_pkt();
    bus.req_i           = 3'b110;
    bus.l2req_ready     = 1'b1;
    cycle();
    chk("post_rst_grant", 128'(obs_grant), 128'(3'b010));

    // randomized traffic: requests held until granted, random L2 backpressure
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (bus.req_i[i] && m_grant[i]) begin
          bus.req_i[i]        = 1'($urandom_range(0, 1));
          bus.req_packet_i[i] = rand_pkt();
        end else if (!bus.req_i[i] && ($urandom_range(0, 2) == 0)) begin
          bus.req_i[i]        = 1'b1;
          bus.req_packet_i[i] = rand_pkt();
        end
      end
      bus.l2req_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/l1_l2_request_arbiter.md
L1_L2_REQUEST_ARBITER -- requirements
Module: l1_l2_request_arbiter

Interface
REQ-001 SHALL have parameter CORE_ID, default 0, meaning the core index stamped into every forwarded packet's core field.
REQ-002 SHALL have parameter NUM_REQ, default 3, meaning the number of requesters (0=icache miss queue, 1=dcache miss queue, 2=store buffer).
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req_i, input, NUM_REQ bits: per-requester request valid.
REQ-006 SHALL have port req_packet_i, input, NUM_REQ x l2req_packet_t: per-requester packet.
REQ-007 SHALL have port grant_o, output, NUM_REQ bits: one-hot acceptance pulse.
REQ-008 SHALL have port l2req_ready, input, 1 bit: the L2 accepts the presented packet this cycle.
REQ-009 SHALL have port l2req_packet, output, l2req_packet_t: the registered packet to the L2.
REQ-010 SHALL have port pc_event_l2_stall, output, 1 bit: a packet is valid and not accepted.

Function
REQ-011 Requester i SHALL hold req_i[i] and req_packet_i[i] stable until grant_o[i]=1; the arbiter SHALL never drop an asserted request.
REQ-012 The FSM SHALL have states IDLE (output register empty) and PRESENT (output register holds a packet with l2req_packet.valid=1).
REQ-013 The FSM SHALL define the capture condition load_ok = (state==IDLE) || (state==PRESENT && l2req_ready).
REQ-014 When load_ok=1 and any req_i bit is set, the arbiter SHALL assert exactly one grant_o bit combinationally in the same cycle and capture that packet into the output register at the clock edge; the next state SHALL be PRESENT.
REQ-015 When load_ok=1 and no req_i bit is set, the next state SHALL be IDLE and l2req_packet.valid SHALL be 0.
REQ-016 In PRESENT with l2req_ready=0, the output register SHALL be held bit-stable and grant_o SHALL be 0.
REQ-017 Latency SHALL be 1 cycle from grant to l2req_packet.valid, and accept-and-reload in the same cycle SHALL give back-to-back packets with no bubble.
REQ-018 Selection SHALL be round-robin: the search starts at rr_ptr and proceeds upward modulo NUM_REQ; after a grant to index g, rr_ptr SHALL become (g+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0.
REQ-019 rr_ptr SHALL be unchanged in any cycle with no grant.
REQ-020 The captured packet's core field SHALL be forced to CORE_ID and its valid field forced to 1; all other fields SHALL pass through unchanged.
REQ-021 pc_event_l2_stall SHALL equal (state==PRESENT && !l2req_ready).
REQ-022 If all requesters are asserted continuously, each requester SHALL be granted once per NUM_REQ grants, so no starvation is possible.
REQ-023 The arbiter SHALL assert that grant_o is one-hot-or-zero and that grant_o[i] implies req_i[i].

Reset
REQ-024 Asserting reset_n=0 SHALL asynchronously force state=IDLE, rr_ptr=0 and the output register to all zeros, so l2req_packet.valid=0; grant_o SHALL be 0 while reset_n=0.
REQ-025 When reset is asserted mid-PRESENT, the pending packet SHALL be discarded; requesters re-present after reset.

Structure
REQ-026 l2req_packet_t, the unit_id_t encodings and the requester index constants SHALL live in the shared defines/package; no new typedefs are local to this block.
REQ-027 Round-robin selection SHALL be one sub-module, rr_arbiter (inputs request, pointer; output one-hot grant), and it SHALL be reusable by other arbiters.

Verification
REQ-028 The bench SHALL cover: after reset, req_i=3'b111 with l2req_ready=1 constantly -> grants in order 0,1,2,0,1,2 on consecutive cycles with l2req_packet.valid=1 every cycle from cycle 2.
REQ-029 The bench SHALL cover: req_i=3'b010, l2req_ready=0 for 4 cycles -> one grant, packet held bit-identical for 4 cycles, pc_event_l2_stall=1 for 4 cycles, no second grant.
REQ-030 The bench SHALL cover: rr_ptr=2 with req_i=3'b011 -> grant_o=3'b001 (wrap) and rr_ptr becomes 1.
REQ-031 The bench SHALL cover: a single packet accepted with no new requests -> valid drops to 0 the next cycle and state=IDLE.
REQ-032 The bench SHALL cover: reset_n pulsed low mid-PRESENT, asynchronously between clock edges -> valid=0 immediately and rr_ptr=0; the first grant after reset goes to the lowest asserted index.
REQ-033 The bench SHALL cover: a packet with core field 3 and CORE_ID=1 -> the output core field equals 1.
